imem_boot_loader: RTL and testbench

- On-chip instruction memory plus boot loader sitting directly upstream of the cpu.
- Serves `instruction` for the cpu's `PC_out`.
- Accepts a program as a little-endian byte stream over a valid/ready handshake and writes it into memory.
- Holds the cpu in reset while a program loads and releases it once loading completes.

---
 rtl/imem_boot_loader.sv | 96 +++++++++
 tb/tb_imem_boot_loader.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_boot_loader.sv
// imem_boot_loader: instruction memory with byte-stream program loader that holds the cpu in reset while loading.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   load_start, load_len  begin a load of load_len words (clamped to DEPTH)
//   byte_in, byte_valid   little-endian program byte stream
//   byte_ready            loader accepts a byte (high throughout LOAD)
//   PC_in, instruction    combinational fetch port for the cpu
//   cpu_rst_n             registered active-low cpu reset, high only in RUN
//   busy, fault           loading indicator, sticky illegal-fetch flag
module imem_boot_loader #(
    parameter int          DEPTH    = 256,
    parameter int          ADDR_W   = 8,
    parameter logic [31:0] NOP_WORD = 32'h0000_0013
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_start,
    input  logic [ADDR_W:0]   load_len,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    input  logic [31:0]       PC_in,
    output logic [31:0]       instruction,
    output logic              cpu_rst_n,
    output logic              busy,
    output logic              fault
);
    localparam logic [ADDR_W:0] MAX_LEN = (ADDR_W + 1)'(DEPTH);
    typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;
    state_t state_q, state_d;
    logic [ADDR_W:0] len_q, len_d, ptr_q, ptr_d;
    logic [1:0] cnt_q, cnt_d;
    logic [31:0] asm_q, asm_d;
    logic fault_q, fault_d, cpu_rst_n_q;
    logic start, xfer, we, illegal;
    logic [31:0] mem [DEPTH];
    assign start = load_start && state_q != LOAD;
    // A zero-length load accepts nothing; bytes offered then are dropped.
    assign xfer = state_q == LOAD && byte_valid && len_q != '0;
    assign we = xfer && cnt_q == 2'd3;
    assign illegal = PC_in[1:0] != 2'b00 || PC_in[31:ADDR_W+2] != '0;
    assign instruction = illegal ? NOP_WORD : mem[PC_in[ADDR_W+1:2]];
    assign byte_ready = state_q == LOAD;
    assign busy = state_q == LOAD;
    assign cpu_rst_n = cpu_rst_n_q;
    assign fault = fault_q;
    always_comb begin
        state_d = state_q;
        len_d = len_q;
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        asm_d = asm_q;
        fault_d = fault_q;
        if (start) begin
            state_d = LOAD;
            len_d = load_len > MAX_LEN ? MAX_LEN : load_len;
            ptr_d = '0;
            cnt_d = '0;
            asm_d = '0;
            fault_d = 1'b0;
        end else if (state_q == LOAD) begin
            if (len_q == '0) state_d = RUN;
            else if (xfer) begin
                cnt_d = cnt_q + 2'd1;
                asm_d[{cnt_q, 3'b000} +: 8] = byte_in;
                if (we) ptr_d = ptr_q + 1'b1;
                if (we && ptr_q + 1'b1 == len_q) state_d = RUN;
            end
        end else if (state_q == RUN && illegal) begin
            fault_d = 1'b1;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            len_q <= '0;
            ptr_q <= '0;
            cnt_q <= '0;
            asm_q <= '0;
            fault_q <= 1'b0;
            cpu_rst_n_q <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q <= len_d;
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
            asm_q <= asm_d;
            fault_q <= fault_d;
            cpu_rst_n_q <= state_d == RUN;
        end
    end
    // Memory is deliberately outside the reset domain so programs survive rst_n.
    always_ff @(posedge clk) begin
        if (we) mem[ptr_q[ADDR_W-1:0]] <= {byte_in, asm_q[23:0]};
    end
endmodule

// File: tb/tb_imem_boot_loader.sv
// tb_imem_boot_loader: directed self-checking bench for imem_boot_loader.
module tb_imem_boot_loader;
    logic clk = 1'b0, rst_n = 1'b0, load_start = 1'b0, byte_valid = 1'b0;
    logic [8:0] load_len = '0;
    logic [7:0] byte_in = '0;
    logic [31:0] PC_in = '0;
    logic byte_ready, cpu_rst_n, busy, fault;
    logic [31:0] instruction;
    int total = 0, bad = 0;
    logic [7:0] prog [8] = '{8'h93, 8'h81, 8'h26, 8'h02, 8'h93, 8'h0E, 8'h60, 8'h0C};

    imem_boot_loader dut (
        .clk(clk), .rst_n(rst_n), .load_start(load_start), .load_len(load_len),
        .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready),
        .PC_in(PC_in), .instruction(instruction), .cpu_rst_n(cpu_rst_n),
        .busy(busy), .fault(fault)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic start_load(input logic [8:0] len);
        load_start = 1'b1;
        load_len = len;
        tick();
        load_start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        byte_in = b;
        byte_valid = 1'b1;
        tick();
        byte_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #3;
        total++;
        if ({cpu_rst_n, byte_ready, busy, fault} !== 4'b0000) begin
            bad++;
            $display("FAIL reset_outputs got=%b exp=0000", {cpu_rst_n, byte_ready, busy, fault});
        end
        tick();
        rst_n = 1'b1;
        tick();
        total++;
        if (cpu_rst_n !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL idle_after_reset cpu_rst_n=%b busy=%b exp 0 0", cpu_rst_n, busy);
        end
    endtask

    task automatic test_load;
        start_load(9'd2);
        total++;
        if ({busy, byte_ready, cpu_rst_n} !== 3'b110) begin
            bad++;
            $display("FAIL load_entry got=%b exp=110", {busy, byte_ready, cpu_rst_n});
        end
        for (int i = 0; i < 8; i++) begin
            send_byte(prog[i]);
            if (i == 6) begin
                total++;
                if (cpu_rst_n !== 1'b0 || busy !== 1'b1) begin
                    bad++;
                    $display("FAIL load_7th cpu_rst_n=%b busy=%b exp 0 1", cpu_rst_n, busy);
                end
            end
        end
        total++;
        if (cpu_rst_n !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL load_done cpu_rst_n=%b busy=%b exp 1 0", cpu_rst_n, busy);
        end
        PC_in = 32'd0;
        #1;
        total++;
        if (instruction !== 32'h0226_8193) begin
            bad++;
            $display("FAIL load_word0 got=%h exp=02268193", instruction);
        end
        PC_in = 32'd4;
        #1;
        total++;
        if (instruction !== 32'h0C60_0E93) begin
            bad++;
            $display("FAIL load_word1 got=%h exp=0c600e93", instruction);
        end
        PC_in = 32'd0;
    endtask

    task automatic test_stall;
        start_load(9'd2);
        total++;
        if (cpu_rst_n !== 1'b0) begin
            bad++;
            $display("FAIL stall_rst_drop got=%b exp=0", cpu_rst_n);
        end
        for (int i = 0; i < 15; i++) begin
            byte_valid = (i % 2 == 0);
            byte_in = (i % 2 == 0) ? prog[i/2] : 8'hFF;
            #1;
            total++;
            if (byte_ready !== 1'b1 || cpu_rst_n !== 1'b0) begin
                bad++;
                $display("FAIL stall_step%0d ready=%b cpu_rst_n=%b exp 1 0", i, byte_ready, cpu_rst_n);
            end
            tick();
        end
        byte_valid = 1'b0;
        total++;
        if (cpu_rst_n !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL stall_done cpu_rst_n=%b busy=%b exp 1 0", cpu_rst_n, busy);
        end
        PC_in = 32'd0;
        #1;
        total++;
        if (instruction !== 32'h0226_8193) begin
            bad++;
            $display("FAIL stall_word0 got=%h exp=02268193", instruction);
        end
        PC_in = 32'd4;
        #1;
        total++;
        if (instruction !== 32'h0C60_0E93) begin
            bad++;
            $display("FAIL stall_word1 got=%h exp=0c600e93", instruction);
        end
        PC_in = 32'd0;
    endtask

    task automatic test_fault;
        PC_in = 32'h2;
        #1;
        total++;
        if (instruction !== 32'h0000_0013 || fault !== 1'b0) begin
            bad++;
            $display("FAIL misaligned instr=%h fault=%b exp 00000013 0", instruction, fault);
        end
        tick();
        total++;
        if (fault !== 1'b1) begin
            bad++;
            $display("FAIL fault_set got=%b exp=1", fault);
        end
        PC_in = 32'd1024;
        #1;
        total++;
        if (instruction !== 32'h0000_0013) begin
            bad++;
            $display("FAIL out_of_range got=%h exp=00000013", instruction);
        end
        PC_in = 32'd0;
        tick();
        tick();
        total++;
        if (fault !== 1'b1 || instruction !== 32'h0226_8193) begin
            bad++;
            $display("FAIL fault_sticky fault=%b instr=%h exp 1 02268193", fault, instruction);
        end
    endtask

    task automatic test_zero_len;
        start_load(9'd0);
        total++;
        if ({busy, fault, cpu_rst_n} !== 3'b100) begin
            bad++;
            $display("FAIL zero_entry busy_fault_rst=%b exp=100", {busy, fault, cpu_rst_n});
        end
        tick();
        total++;
        if (busy !== 1'b0 || cpu_rst_n !== 1'b1) begin
            bad++;
            $display("FAIL zero_run busy=%b cpu_rst_n=%b exp 0 1", busy, cpu_rst_n);
        end
        PC_in = 32'd4;
        #1;
        total++;
        if (instruction !== 32'h0C60_0E93) begin
            bad++;
            $display("FAIL zero_mem got=%h exp=0c600e93", instruction);
        end
        PC_in = 32'd0;
    endtask

    task automatic test_reset_mid;
        logic [7:0] b [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        start_load(9'd2);
        for (int i = 0; i < 5; i++) send_byte(b[i]);
        rst_n = 1'b0;
        #1;
        total++;
        if ({cpu_rst_n, busy, byte_ready} !== 3'b000) begin
            bad++;
            $display("FAIL midreset_outputs got=%b exp=000", {cpu_rst_n, busy, byte_ready});
        end
        PC_in = 32'd0;
        #1;
        total++;
        if (instruction !== 32'h4433_2211) begin
            bad++;
            $display("FAIL midreset_word0 got=%h exp=44332211", instruction);
        end
        PC_in = 32'd4;
        #1;
        total++;
        if (instruction !== 32'h0C60_0E93) begin
            bad++;
            $display("FAIL midreset_word1 got=%h exp=0c600e93", instruction);
        end
        PC_in = 32'd0;
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        total++;
        if (cpu_rst_n !== 1'b0) begin
            bad++;
            $display("FAIL midreset_hold got=%b exp=0", cpu_rst_n);
        end
    endtask

    task automatic test_reload;
        start_load(9'd0);
        tick();
        total++;
        if (cpu_rst_n !== 1'b1) begin
            bad++;
            $display("FAIL reload_prerun got=%b exp=1", cpu_rst_n);
        end
        start_load(9'd1);
        total++;
        if (cpu_rst_n !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL reload_drop cpu_rst_n=%b busy=%b exp 0 1", cpu_rst_n, busy);
        end
        send_byte(8'h13);
        load_start = 1'b1;
        load_len = 9'd0;
        send_byte(8'h0A);
        load_start = 1'b0;
        send_byte(8'hF0);
        total++;
        if (cpu_rst_n !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL reload_ignore_start cpu_rst_n=%b busy=%b exp 0 1", cpu_rst_n, busy);
        end
        PC_in = 32'd0;
        byte_in = 8'h0C;
        byte_valid = 1'b1;
        #1;
        total++;
        if (instruction !== 32'h4433_2211) begin
            bad++;
            $display("FAIL same_cycle_old got=%h exp=44332211", instruction);
        end
        tick();
        byte_valid = 1'b0;
        total++;
        if (instruction !== 32'h0CF0_0A13 || cpu_rst_n !== 1'b1) begin
            bad++;
            $display("FAIL reload_done instr=%h cpu_rst_n=%b exp 0cf00a13 1", instruction, cpu_rst_n);
        end
        PC_in = 32'd4;
        #1;
        total++;
        if (instruction !== 32'h0C60_0E93) begin
            bad++;
            $display("FAIL reload_word1 got=%h exp=0c600e93", instruction);
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_stall();
        test_fault();
        test_zero_len();
        test_reset_mid();
        test_reload();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
